// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU MEM-stage port, the external word master port and the data-memory port.
// The arbiter connects through the slave modport; the requesters and the DM use the master side.
interface dm_port_arbiter_if #(
  parameter int AW = 12
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW+1:0] cpu_addr;
  logic [1:0]    cpu_size;
  logic          cpu_sext;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic          cpu_misalign;

  logic          ext_req;
  logic          ext_we;
  logic [AW+1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic          ext_ack;
  logic [31:0]   ext_rdata;

  logic [AW-1:0] dm_a;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [31:0]   dm_d;
  logic [31:0]   dm_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_sext, cpu_wdata,
    output cpu_rdata, cpu_stall, cpu_misalign,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output dm_a, dm_we, dm_be, dm_d,
    input  dm_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_sext, cpu_wdata,
    input  cpu_rdata, cpu_stall, cpu_misalign,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  dm_a, dm_we, dm_be, dm_d,
    output dm_dout
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and an external word master.
// Define DM_MISALIGN_TRAP_EN to flag misaligned CPU accesses instead of silently aligning them.
module dm_port_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dm_port_arbiter_if.slave     bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    C_OWN  = 1'b0,
    E_XFER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_waitCnt;
  logic            r_extAck;
  logic [31:0]     r_extRdata;

  logic            w_extPending;
  logic            w_starved;
  logic            w_enterE;
  logic            w_isWord;
  logic            w_isHalf;
  logic [1:0]      w_lo;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [7:0]      w_loadByte;
  logic [15:0]     w_loadHalf;
  logic [31:0]     w_loadData;
  logic [AW-1:0]   w_cpuWordA;
  logic [AW-1:0]   w_extWordA;

  assign w_isWord = bus.cpu_size[1];
  assign w_isHalf = (bus.cpu_size == 2'b01);

`ifdef DM_MISALIGN_TRAP_EN
  assign w_lo       = bus.cpu_addr[1:0];
  assign w_misalign = (w_isHalf & bus.cpu_addr[0]) | (w_isWord & (bus.cpu_addr[1:0] != 2'b00));
  assign bus.cpu_misalign = bus.cpu_req & w_misalign;
`else
  // Low address bits are forced to the natural alignment of the access size.
  assign w_lo       = w_isWord ? 2'b00 : (w_isHalf ? {bus.cpu_addr[1], 1'b0} : bus.cpu_addr[1:0]);
  assign w_misalign = 1'b0;
  assign bus.cpu_misalign = 1'b0;
`endif

  // Addresses beyond the DM size wrap modulo 2^AW words through truncation.
  assign w_cpuWordA = AW'(bus.cpu_addr >> 2);
  assign w_extWordA = AW'(bus.ext_addr >> 2);

  always_comb begin
    w_be = 4'b0001 << w_lo;
    if (w_isWord) begin
      w_be = 4'b1111;
    end else if (w_isHalf) begin
      w_be = w_lo[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign w_loadByte = 8'(bus.dm_dout >> {w_lo, 3'b000});
  assign w_loadHalf = 16'(bus.dm_dout >> {w_lo[1], 4'b0000});

  always_comb begin
    w_loadData = bus.dm_dout;
    if (w_misalign) begin
      w_loadData = 32'h0;
    end else if (w_isWord) begin
      w_loadData = bus.dm_dout;
    end else if (w_isHalf) begin
      w_loadData = {{16{bus.cpu_sext & w_loadHalf[15]}}, w_loadHalf};
    end else begin
      w_loadData = {{24{bus.cpu_sext & w_loadByte[7]}}, w_loadByte};
    end
  end

  assign bus.cpu_rdata = w_loadData;

  // A request still held during its own ack cycle must not be accepted a second time.
  assign w_extPending = bus.ext_req & ~r_extAck;
  assign w_starved    = (r_waitCnt == CW'(STARVE_LIMIT));

  always_comb begin
    w_nextState = r_state;
    w_enterE    = 1'b0;
    case (r_state)
      C_OWN: begin
        if (w_extPending & (~bus.cpu_req | w_starved)) begin
          w_nextState = E_XFER;
          w_enterE    = 1'b1;
        end
      end
      E_XFER: begin
        w_nextState = C_OWN;
      end
      default: begin
        w_nextState = C_OWN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= C_OWN;
      r_waitCnt  <= '0;
      r_extAck   <= 1'b0;
      r_extRdata <= 32'h0;
    end else begin
      r_state  <= w_nextState;
      r_extAck <= (r_state == E_XFER);
      if (r_state == E_XFER) begin
        r_extRdata <= bus.dm_dout;
      end
      if (w_enterE) begin
        r_waitCnt <= '0;
      end else if ((r_state == C_OWN) && w_extPending && bus.cpu_req && !w_starved) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
    end
  end

  assign bus.ext_ack   = r_extAck;
  assign bus.ext_rdata = r_extRdata;
  assign bus.cpu_stall = (r_state == E_XFER) & bus.cpu_req;

  always_comb begin
    bus.dm_a  = w_cpuWordA;
    bus.dm_we = bus.cpu_req & bus.cpu_we & ~w_misalign;
    bus.dm_be = w_be;
    bus.dm_d  = bus.cpu_wdata;
    if (r_state == E_XFER) begin
      bus.dm_a  = w_extWordA;
      bus.dm_we = bus.ext_we;
      bus.dm_be = 4'hf;
      bus.dm_d  = bus.ext_wdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a lane-steering word memory model.
// Expectations for misaligned stores follow DM_MISALIGN_TRAP_EN when it is defined.
module tb_dm_port_arbiter;

  localparam int AW = 12;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;

  dm_port_arbiter_if #(.AW(AW)) bus ();

  dm_port_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:(1<<AW)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dm_dout = mem[bus.dm_a];

  // Right-justified store data is steered to the lanes selected by the byte enables.
  always @(posedge clk) begin
    if (bus.dm_we) begin
      case (bus.dm_be)
        4'b1111: mem[bus.dm_a]        <= bus.dm_d;
        4'b0011: mem[bus.dm_a][15:0]  <= bus.dm_d[15:0];
        4'b1100: mem[bus.dm_a][31:16] <= bus.dm_d[15:0];
        4'b0001: mem[bus.dm_a][7:0]   <= bus.dm_d[7:0];
        4'b0010: mem[bus.dm_a][15:8]  <= bus.dm_d[7:0];
        4'b0100: mem[bus.dm_a][23:16] <= bus.dm_d[7:0];
        4'b1000: mem[bus.dm_a][31:24] <= bus.dm_d[7:0];
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [AW+1:0] addr,
                               input logic [1:0] size, input logic sext, input logic [31:0] wdata);
    @(negedge clk);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_size  = size;
    bus.cpu_sext  = sext;
    bus.cpu_wdata = wdata;
    #1;
  endtask

  task automatic extDrive(input logic req, input logic we, input logic [AW+1:0] addr,
                          input logic [31:0] wdata);
    bus.ext_req   = req;
    bus.ext_we    = we;
    bus.ext_addr  = addr;
    bus.ext_wdata = wdata;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // CPU load held continuously while E requests a read of word 0x10.
  task automatic runStarve(input string tag, input logic [31:0] expRd);
    applyStimulus(1'b1, 1'b0, 14'h10, 2'b10, 1'b0, 32'h0);
    extDrive(1'b1, 1'b0, 14'h10, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_stall%0d", tag, i), {31'b0, bus.cpu_stall}, {31'b0, (i == 5)});
      checkOutput($sformatf("%s_ack%0d", tag, i), {31'b0, bus.ext_ack}, {31'b0, (i == 6)});
      if (i == 6) begin
        checkOutput({tag, "_erd"}, bus.ext_rdata, expRd);
        extDrive(1'b0, 1'b0, 14'h0, 32'h0);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 14'h0, 2'b10, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_size = 2'b00;
    bus.cpu_sext = 1'b0; bus.cpu_wdata = 32'h0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_ack", {31'b0, bus.ext_ack}, 32'h0);
    checkOutput("rst_erd", bus.ext_rdata, 32'h0);
    checkOutput("rst_stall", {31'b0, bus.cpu_stall}, 32'h0);
    rst_n = 1'b1;

    // Word store then load, plus address wrap
    applyStimulus(1'b1, 1'b1, 14'h10, 2'b10, 1'b0, 32'h12345678);
    checkOutput("sw_be", {28'b0, bus.dm_be}, 32'hf);
    checkOutput("sw_we", {31'b0, bus.dm_we}, 32'h1);
    checkOutput("sw_stall", {31'b0, bus.cpu_stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 14'h10, 2'b10, 1'b0, 32'h0);
    checkOutput("lw", bus.cpu_rdata, 32'h12345678);
    checkOutput("lw_stall", {31'b0, bus.cpu_stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, 14'h3ffc, 2'b10, 1'b0, 32'h0);
    checkOutput("wrap_a", {20'b0, bus.dm_a}, 32'hfff);
    checkOutput("idle_we", {31'b0, bus.dm_we}, 32'h0);

    // Sub-word stores and loads
    applyStimulus(1'b1, 1'b1, 14'h13, 2'b00, 1'b0, 32'h000000ab);
    checkOutput("sb_be", {28'b0, bus.dm_be}, 32'h8);
    applyStimulus(1'b1, 1'b0, 14'h13, 2'b00, 1'b1, 32'h0);
    checkOutput("lb", bus.cpu_rdata, 32'hffffffab);
    applyStimulus(1'b1, 1'b0, 14'h13, 2'b00, 1'b0, 32'h0);
    checkOutput("lbu", bus.cpu_rdata, 32'h000000ab);
    applyStimulus(1'b1, 1'b1, 14'h12, 2'b01, 1'b0, 32'h00008001);
    checkOutput("sh_be", {28'b0, bus.dm_be}, 32'hc);
    applyStimulus(1'b1, 1'b0, 14'h12, 2'b01, 1'b1, 32'h0);
    checkOutput("lh", bus.cpu_rdata, 32'hffff8001);
    applyStimulus(1'b1, 1'b0, 14'h11, 2'b00, 1'b1, 32'h0);
    checkOutput("lb_lane1", bus.cpu_rdata, 32'h00000056);
    applyStimulus(1'b1, 1'b0, 14'h10, 2'b01, 1'b0, 32'h0);
    checkOutput("lhu_lo", bus.cpu_rdata, 32'h00005678);

    // External write then read with the CPU idle
    applyStimulus(1'b0, 1'b0, 14'h0, 2'b10, 1'b0, 32'h0);
    extDrive(1'b1, 1'b1, 14'h20, 32'hdeadbeef);
    checkOutput("ew_ack0", {31'b0, bus.ext_ack}, 32'h0);
    nextCycle();
    checkOutput("ew_we", {31'b0, bus.dm_we}, 32'h1);
    checkOutput("ew_be", {28'b0, bus.dm_be}, 32'hf);
    checkOutput("ew_a", {20'b0, bus.dm_a}, 32'h8);
    checkOutput("ew_stall", {31'b0, bus.cpu_stall}, 32'h0);
    nextCycle();
    checkOutput("ew_ack", {31'b0, bus.ext_ack}, 32'h1);
    nextCycle();
    extDrive(1'b0, 1'b0, 14'h0, 32'h0);
    checkOutput("ew_ack_once", {31'b0, bus.ext_ack}, 32'h0);
    checkOutput("ew_no_rexfer", {31'b0, bus.dm_we}, 32'h0);
    extDrive(1'b1, 1'b0, 14'h20, 32'h0);
    nextCycle();
    checkOutput("er_we", {31'b0, bus.dm_we}, 32'h0);
    nextCycle();
    checkOutput("er_ack", {31'b0, bus.ext_ack}, 32'h1);
    checkOutput("er_rdata", bus.ext_rdata, 32'hdeadbeef);
    extDrive(1'b0, 1'b0, 14'h0, 32'h0);
    nextCycle();

    // Starvation limit forces E in while the CPU keeps requesting
    runStarve("starve", 32'h80015678);

    // Misaligned word store to 0x02
    applyStimulus(1'b1, 1'b1, 14'h02, 2'b10, 1'b0, 32'hcafef00d);
`ifdef DM_MISALIGN_TRAP_EN
    checkOutput("mis_flag", {31'b0, bus.cpu_misalign}, 32'h1);
    checkOutput("mis_we", {31'b0, bus.dm_we}, 32'h0);
    applyStimulus(1'b1, 1'b0, 14'h00, 2'b10, 1'b0, 32'h0);
    checkOutput("mis_word0", bus.cpu_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 14'h11, 2'b01, 1'b0, 32'h0);
    checkOutput("mis_lh_flag", {31'b0, bus.cpu_misalign}, 32'h1);
    checkOutput("mis_lh_rd", bus.cpu_rdata, 32'h0);
`else
    checkOutput("mis_flag", {31'b0, bus.cpu_misalign}, 32'h0);
    checkOutput("mis_we", {31'b0, bus.dm_we}, 32'h1);
    checkOutput("mis_be", {28'b0, bus.dm_be}, 32'hf);
    applyStimulus(1'b1, 1'b0, 14'h00, 2'b10, 1'b0, 32'h0);
    checkOutput("mis_word0", bus.cpu_rdata, 32'hcafef00d);
    applyStimulus(1'b1, 1'b0, 14'h11, 2'b01, 1'b0, 32'h0);
    checkOutput("mis_lh_flag", {31'b0, bus.cpu_misalign}, 32'h0);
    checkOutput("mis_lh_rd", bus.cpu_rdata, 32'h00005678);
`endif

    // Reset in the middle of an external transfer
    applyStimulus(1'b0, 1'b0, 14'h0, 2'b10, 1'b0, 32'h0);
    extDrive(1'b1, 1'b1, 14'h30, 32'h11111111);
    nextCycle();
    checkOutput("rx_we", {31'b0, bus.dm_we}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rx_we_kill", {31'b0, bus.dm_we}, 32'h0);
    extDrive(1'b0, 1'b0, 14'h0, 32'h0);
    nextCycle();
    checkOutput("rx_ack0", {31'b0, bus.ext_ack}, 32'h0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rx_ack1", {31'b0, bus.ext_ack}, 32'h0);
    applyStimulus(1'b1, 1'b0, 14'h30, 2'b10, 1'b0, 32'h0);
    checkOutput("rx_stall", {31'b0, bus.cpu_stall}, 32'h0);
    checkOutput("rx_nowrite", bus.cpu_rdata, 32'h0);
    runStarve("rx_starve", 32'h80015678);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
